signed_muldiv_sequencer: RTL and testbench
==========================================

SIGNED_MULDIV_SEQUENCER -- requirements
Module: signed_muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter ITER_COUNT, default 8, meaning the number of iteration cycles per operation (operand width).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1, meaning a request is present.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept a request.
REQ-006 The block SHALL have port op, input, 1, selecting the operation: 0 = multiply, 1 = divide.
REQ-007 The block SHALL have ports a and b, input, 8 each, two's-complement operands (dividend and divisor for divide).
REQ-008 The block SHALL have port out_valid, output, 1, meaning the result is held and valid.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-010 The block SHALL have port result, output, 16: the signed product for multiply, or {remainder[7:0], quotient[7:0]} for divide.
REQ-011 The block SHALL have port div_by_zero, output, 1, set with the result when op=1 and b=0.
REQ-012 The block SHALL have port ovf, output, 1, set with the result only for divide -128 / -1.

Function
REQ-013 FSM states SHALL be IDLE, ITER, FIX and DONE; in_ready = (state==IDLE), combinational.
REQ-014 Acceptance SHALL occur on the edge where in_valid && in_ready. On that edge the block SHALL capture op, |a| and |b| as 8-bit unsigned magnitudes (|-128| = 128), and the sign flags.
REQ-015 Sign flags: result_neg = a[7]^b[7]; rem_neg = a[7] (divide only).
REQ-016 After acceptance the state SHALL be ITER, with the iteration counter = 0.
REQ-017 Multiply, each ITER cycle: if multiplier LSB = 1, add the multiplicand to the upper accumulator; then shift {carry, acc} right 1 (unsigned shift-add).
REQ-018 Divide, each ITER cycle: restoring step — shift {rem, quot} left 1, trial-subtract |b|; if the result is non-negative keep it and set quot LSB = 1, otherwise restore.
REQ-019 After ITER_COUNT ITER cycles the state SHALL go to FIX.
REQ-020 FIX, one cycle: negate the 16-bit product if result_neg. For divide, negate the quotient if result_neg and the remainder if rem_neg, each 8-bit two's complement. Then go to DONE.
REQ-021 Latency SHALL be fixed: out_valid is high after edge acceptance+ITER_COUNT+1 (9 cycles for the default).
REQ-022 Divide with b=0 SHALL skip ITER and FIX: go IDLE->DONE on the acceptance edge, result = 16'h0000, div_by_zero = 1.
REQ-023 Divide -128 / -1 SHALL produce quotient 8'h80, remainder 8'h00, ovf = 1.
REQ-024 In DONE, result, div_by_zero and ovf SHALL be held stable while out_valid = 1 && out_ready = 0.
REQ-025 The state SHALL leave DONE for IDLE on the edge where out_valid && out_ready; the next request is accepted no earlier than the following edge.
REQ-026 Changes on in_valid, op, a and b outside the acceptance edge SHALL have no effect on an operation in progress.
REQ-027 div_by_zero and ovf SHALL be 0 for every multiply and for every divide not covered by REQ-022 and REQ-023.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, out_valid 0, result 16'h0000, div_by_zero 0, ovf 0, counter 0, all operand and accumulator registers 0.
REQ-029 in_ready SHALL read 1 during and after reset.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no result delivered; the first request after deassertion SHALL complete normally.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, ITER, FIX, DONE), the op encoding constants (OP_MUL, OP_DIV) and the default ITER_COUNT.
REQ-032 One sub-module, muldiv_step, SHALL implement a single combinational shift-add or shift-subtract iteration selected by op; the sequencer instantiates it once and registers its outputs.
REQ-033 Magnitude and negation logic SHALL be combinational within the sequencer; it SHALL NOT introduce extra pipeline stages.

Verification
REQ-034 Multiply a=8'hFD (-3), b=8'h05 -> result 16'hFFF1, out_valid 9 cycles after acceptance, flags 0.
REQ-035 Multiply a=8'h80, b=8'h80 -> result 16'h4000; a=8'h7F, b=8'h80 -> result 16'hC080.
REQ-036 Divide a=8'hF9 (-7), b=8'h02 -> result 16'hFFFD (rem -1, quot -3); divide a=8'h80, b=8'hFF -> result 16'h0080, ovf = 1.
REQ-037 Divide with b=8'h00 -> out_valid on the cycle after acceptance, result 16'h0000, div_by_zero = 1.
REQ-038 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> result stable and in_ready 0 throughout; release it, then back-to-back requests each complete with the correct result.
REQ-039 Pulse rst_n low during ITER cycle 4 -> all outputs reset immediately, out_valid never asserts for the aborted request, and a following multiply 8'h02 x 8'h03 -> 16'h0006.

Source files
------------

// File: rtl/signed_muldiv_sequencer_pkg.sv
// signed_muldiv_sequencer_pkg: shared FSM states, op encoding and default operand width
package signed_muldiv_sequencer_pkg;
  localparam int ITER_COUNT_DEF = 8;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one unsigned shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step
  import signed_muldiv_sequencer_pkg::*;
#(
  parameter int W = ITER_COUNT_DEF
) (
  input  logic         op,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] m,
  output logic [W-1:0] hi_n,
  output logic [W-1:0] lo_n
);
  logic [W:0]   sum;
  logic [W:0]   sh;
  logic [W-1:0] diff;
  logic         ge;
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    sh   = {hi, lo[W-1]};
    ge   = sh >= {1'b0, m};
    diff = sh[W-1:0] - m;
    hi_n = (op == OP_MUL) ? sum[W:1] : (ge ? diff : sh[W-1:0]);
    lo_n = (op == OP_MUL) ? {sum[0], lo[W-1:1]} : {lo[W-2:0], ge};
  end
endmodule

// File: rtl/signed_muldiv_sequencer.sv
// signed_muldiv_sequencer: iterative signed 8x8 multiply / 8/8 divide with valid-ready handshakes
module signed_muldiv_sequencer
  import signed_muldiv_sequencer_pkg::*;
#(
  parameter int ITER_COUNT = ITER_COUNT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op,
  input  logic [ITER_COUNT-1:0]   a,
  input  logic [ITER_COUNT-1:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*ITER_COUNT-1:0] result,
  output logic                    div_by_zero,
  output logic                    ovf
);
  localparam int W  = ITER_COUNT;
  localparam int CW = $clog2(W + 1);
  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic           op_r, res_neg, rem_neg;
  logic [W-1:0]   hi, lo, m, hi_n, lo_n, a_mag, b_mag, q_fix, r_fix;
  logic [2*W-1:0] p_fix;
  logic           accept, last, dbz_in;

  assign a_mag  = a[W-1] ? -a : a;
  assign b_mag  = b[W-1] ? -b : b;
  assign accept = in_valid && in_ready;
  assign last   = cnt == CW'(W - 1);
  assign dbz_in = (op == OP_DIV) && (b == '0);
  assign p_fix  = res_neg ? -{hi, lo} : {hi, lo};
  assign q_fix  = res_neg ? -lo : lo;
  assign r_fix  = rem_neg ? -hi : hi;

  muldiv_step #(.W(W)) u_step (
    .op   (op_r),
    .hi   (hi),
    .lo   (lo),
    .m    (m),
    .hi_n (hi_n),
    .lo_n (lo_n)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;

  always_comb begin
    state_n = state == IDLE ? (accept ? (dbz_in ? DONE : ITER) : IDLE) :
              state == ITER ? (last ? FIX : ITER) :
              state == FIX  ? DONE :
                              (out_ready ? IDLE : DONE);
  end

  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end

  // Only a divide whose quotient magnitude is 2^(W-1) with a positive sign is -128 / -1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_r        <= 1'b0;
      res_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      m           <= '0;
      cnt         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else if (accept) begin
      op_r        <= op;
      res_neg     <= a[W-1] ^ b[W-1];
      rem_neg     <= (op == OP_DIV) && a[W-1];
      hi          <= '0;
      lo          <= a_mag;
      m           <= b_mag;
      cnt         <= '0;
      result      <= '0;
      div_by_zero <= dbz_in;
      ovf         <= 1'b0;
    end else if (state == ITER) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + CW'(1);
    end else if (state == FIX) begin
      result <= (op_r == OP_DIV) ? {r_fix, q_fix} : p_fix;
      ovf    <= (op_r == OP_DIV) && !res_neg && (lo == {1'b1, {(W-1){1'b0}}});
    end
endmodule

// File: tb/tb_signed_muldiv_sequencer.sv
// tb_signed_muldiv_sequencer: directed scoreboard bench for the signed multiply/divide sequencer
module tb_signed_muldiv_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, op = 1'b0, out_ready = 1'b0;
  logic [7:0]  a = 8'h00, b = 8'h00;
  logic        in_ready, out_valid, div_by_zero, ovf;
  logic [15:0] result;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  signed_muldiv_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );
  function automatic logic [17:0] model(input logic o, input logic [7:0] x, input logic [7:0] y);
    int sx, sy, p, q, r;
    sx = $signed(x);
    sy = $signed(y);
    if (!o) begin
      p = sx * sy;
      return {2'b00, p[15:0]};
    end
    if (sy == 0) return {2'b10, 16'h0000};
    q = sx / sy;
    r = sx % sy;
    return {1'b0, q == 128, r[7:0], q[7:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("%s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic o, input logic [7:0] x, input logic [7:0] y, input int hold);
    logic [17:0] e;
    logic [15:0] r0;
    int lat;
    e = model(o, x, y);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    out_ready = 1'b0;
    chk("in_ready before accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = ~o;
    a = 8'hA5;
    b = 8'h5A;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, (o && y == 8'h00) ? 0 : 9);
    chk("result", result, e[15:0]);
    chk("div_by_zero", div_by_zero, e[17]);
    chk("ovf", ovf, e[16]);
    r0 = result;
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold result", result, r0);
      chk("hold in_ready", in_ready, 0);
      chk("hold out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle after handshake", {in_ready, out_valid}, 2'b10);
  endtask
  initial begin
    int seen;
    #1;
    chk("in_ready in reset", in_ready, 1);
    chk("out_valid in reset", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(1'b0, 8'hFD, 8'h05, 0);
    run(1'b0, 8'h80, 8'h80, 0);
    run(1'b0, 8'h7F, 8'h80, 0);
    run(1'b1, 8'hF9, 8'h02, 0);
    run(1'b1, 8'h80, 8'hFF, 0);
    run(1'b1, 8'h33, 8'h00, 0);
    run(1'b1, 8'h64, 8'h07, 5);
    run(1'b0, 8'h0C, 8'hF6, 0);
    run(1'b1, 8'h80, 8'h01, 0);
    @(negedge clk);
    in_valid = 1'b1;
    op = 1'b0;
    a = 8'h7F;
    b = 8'h7F;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst result", result, 0);
    chk("rst flags", {div_by_zero, ovf}, 2'b00);
    chk("rst in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("aborted never valid", seen, 0);
    run(1'b0, 8'h02, 8'h03, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
